// File: rtl/freqmon_pkg.sv
// freqmon_pkg: shared state encoding and tolerance width for the frequency ratio monitor
package freqmon_pkg;
  localparam int TOL_W = 4;
  typedef enum logic [2:0] {IDLE, ARMED, ACQUIRE, LOCKED, FAULT} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, asynchronous active-low reset rst
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/freq_ratio_monitor.sv
// freq_ratio_monitor: measures div_in period in clk cycles and locks/faults against exp_period +/- tol; FREQMON_DUTY_EN adds high-time measurement
module freq_ratio_monitor
  import freqmon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [TOL_W-1:0] tol,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] high_time
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  state_t state, state_nx;
  logic sync_q, hist_q, rise_det, sat, good, meas;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] diff;
  logic [GW-1:0] gcnt, gcnt_nx;

  sync_2ff u_sync (.clk(clk), .rst(rst), .d(div_in), .q(sync_q));

  assign rise_det = sync_q & ~hist_q;
  assign sat      = &cnt;
  assign diff     = (cnt >= exp_period) ? {1'b0, cnt} - {1'b0, exp_period}
                                        : {1'b0, exp_period} - {1'b0, cnt};
  // a saturated count is never a real period, so it can never be good
  assign good     = (exp_period != '0) && !sat && (diff <= {{(CNT_W+1-TOL_W){1'b0}}, tol});
  assign meas     = enable && rise_det && (state == ACQUIRE || state == LOCKED || state == FAULT);

  // lock/fault state machine and consecutive-good counter
  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    if (!enable) begin
      state_nx = IDLE;
      gcnt_nx  = '0;
    end else begin
      case (state)
        IDLE:    state_nx = ARMED;
        ARMED:   state_nx = rise_det ? ACQUIRE : ARMED;
        ACQUIRE:
          if (rise_det) begin
            gcnt_nx  = good ? gcnt + 1'b1 : '0;
            state_nx = (good && gcnt == GW'(LOCK_COUNT - 1)) ? LOCKED : ACQUIRE;
          end else if (sat) begin
            gcnt_nx  = '0;
            state_nx = ARMED;
          end
        LOCKED:  state_nx = ((rise_det && !good) || sat) ? FAULT : LOCKED;
        default: state_nx = state;
      endcase
    end
  end

  // state, period counter, measurement capture and registered status decodes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      gcnt         <= '0;
      hist_q       <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nx;
      gcnt         <= gcnt_nx;
      hist_q       <= sync_q;
      cnt          <= (state == IDLE || !enable) ? '0 : rise_det ? CNT_W'(1) : sat ? cnt : cnt + 1'b1;
      period_valid <= meas;
      period       <= meas ? cnt : period;
      locked       <= state_nx == LOCKED;
      fault        <= state_nx == FAULT;
    end

`ifdef FREQMON_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic fall_det;
  assign fall_det = ~sync_q & hist_q;
  // count synchronized high cycles and latch them on the falling edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      hcnt      <= (state == IDLE || !enable || fall_det) ? '0 : (sync_q && !(&hcnt)) ? hcnt + 1'b1 : hcnt;
      high_time <= (fall_det && enable && state != IDLE) ? hcnt : high_time;
    end
`else
  assign high_time = '0;
`endif
endmodule

// File: tb/tb_freq_ratio_monitor.sv
// tb_freq_ratio_monitor: scoreboard bench for freq_ratio_monitor (CNT_W=8, LOCK_COUNT=4)
module tb_freq_ratio_monitor;
  localparam int CW = 8;
`ifdef FREQMON_DUTY_EN
  localparam int HT = 10;
`else
  localparam int HT = 0;
`endif
  logic clk = 0, rst = 0, enable = 0, div_in = 0;
  logic [CW-1:0] exp_period = '0;
  logic [3:0] tol = '0;
  logic [CW-1:0] period, high_time;
  logic period_valid, locked, fault;
  int vectors = 0, miscompares = 0;
  int exp_q[$];
  bit armed_seen = 0;
  int last_per = 0;

  always #5 clk = ~clk;

  freq_ratio_monitor #(.CNT_W(CW), .LOCK_COUNT(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div_in(div_in),
    .exp_period(exp_period), .tol(tol), .period(period),
    .period_valid(period_valid), .locked(locked), .fault(fault),
    .high_time(high_time)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // every period_valid pulse must match the oldest outstanding expected period
  always @(negedge clk)
    if (rst && period_valid) begin
      if (exp_q.size() == 0) check("unexpected_pv", period_valid, 0);
      else check("period", period, exp_q.pop_front());
    end

  // one div_in cycle: rise, hi cycles high, lo cycles low; ends on a negedge
  task automatic pulse(input int hi, input int lo);
    @(posedge clk);
    if (armed_seen) exp_q.push_back(last_per);
    armed_seen = 1;
    last_per = hi + lo;
    #1 div_in = 1;
    repeat (hi) @(posedge clk);
    #1 div_in = 0;
    repeat (lo - 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm();
    @(posedge clk);
    #1 enable = 1;
    @(negedge clk);
  endtask

  task automatic disarm();
    @(posedge clk);
    #1 enable = 0;
    repeat (3) @(negedge clk);
    armed_seen = 0;
  endtask

  task automatic drained(input string tag);
    repeat (6) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_fault", fault, 0);
    check("rst_high_time", high_time, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);

    exp_period = 30; tol = 1;
    arm();
    for (int k = 1; k <= 6; k++) begin
      pulse(10, 20);
      check("lock_30", locked, k >= 5);
      check("nofault_30", fault, 0);
    end
    check("high_time", high_time, HT);
    pulse(10, 25);
    check("locked_before_35", locked, 1);
    pulse(10, 20);
    check("fault_35", fault, 1);
    check("unlocked_35", locked, 0);
    pulse(10, 20);
    check("fault_sticky", fault, 1);
    drained("drain_fault");
    disarm();
    check("idle_fault", fault, 0);
    check("idle_locked", locked, 0);
    check("period_holds", period, 30);

    tol = 2;
    arm();
    for (int k = 1; k <= 10; k++) begin
      pulse(10, (k % 2) ? 20 : 23);
      check("nolock_30_33", locked, 0);
    end
    drained("drain_alt");
    disarm();
    arm();
    for (int k = 1; k <= 6; k++) begin
      pulse(10, (k % 2) ? 22 : 18);
      check("lock_tol_edge", locked, k >= 5);
    end
    drained("drain_edge");
    disarm();

    exp_period = 0; tol = 15;
    arm();
    for (int k = 1; k <= 6; k++) begin
      pulse(4, 8);
      check("nolock_exp0", locked, 0);
    end
    drained("drain_exp0");
    disarm();

    exp_period = 30; tol = 1;
    arm();
    for (int k = 1; k <= 5; k++) pulse(10, 20);
    check("locked_pre_stop", locked, 1);
    repeat (300) @(negedge clk);
    check("fault_sat", fault, 1);
    check("unlocked_sat", locked, 0);
    drained("drain_sat");
    disarm();
    check("idle_after_sat", fault, 0);

    arm();
    pulse(10, 20);
    pulse(10, 20);
    @(posedge clk);
    exp_q.push_back(30);
    #1 div_in = 1;
    repeat (5) @(posedge clk);
    #3 rst = 0;
    #1;
    check("async_period", period, 0);
    check("async_pv", period_valid, 0);
    check("async_locked", locked, 0);
    check("async_fault", fault, 0);
    check("async_high_time", high_time, 0);
    check("drain_pre_rst", exp_q.size(), 0);
    div_in = 0;
    @(posedge clk);
    #1 rst = 1;
    armed_seen = 0;
    @(negedge clk);
    pulse(10, 20);
    pulse(10, 20);
    drained("drain_post_rst");
    check("period_post_rst", period, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
